// File: rtl/microcode_sequencer.sv
// Microcode sequencer: decodes opcode + T-state + flags into the 16-bit datapath control word.
// Latency: ctrl/last are combinational from step/insn/flags; step and halted update on the rising edge.
// Backpressure: none; the datapath samples ctrl every edge, and halt freezes the step counter until rst.
module microcode_sequencer #(
    parameter int DATA_W    = 8,
    parameter int OPCODE_W  = 4,
    parameter int STEPS     = 8,
    parameter int STEP_W    = 3,
    parameter int FIXED_LEN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] insn,
    input  logic              cf,
    input  logic              zf,
    output logic [15:0]       ctrl,
    output logic [STEP_W-1:0] step,
    output logic              last,
    output logic              halted
);

    // Control word bit positions, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'he;
    localparam logic [3:0] OP_HLT = 4'hf;

    localparam logic [STEP_W-1:0] S0     = '0;
    localparam logic [STEP_W-1:0] S1     = STEP_W'(1);
    localparam logic [STEP_W-1:0] S2     = STEP_W'(2);
    localparam logic [STEP_W-1:0] S3     = STEP_W'(3);
    localparam logic [STEP_W-1:0] S4     = STEP_W'(4);
    localparam logic [STEP_W-1:0] S_LAST = STEP_W'(STEPS - 1);

    logic [OPCODE_W-1:0] opcode;
    logic                op_in_range;
    logic [3:0]          op;
    logic [15:0]         uop;
    logic [STEP_W-1:0]   fin_step;
    logic                last_raw;
    logic                hlt_entry;

    assign opcode = insn[DATA_W-1 -: OPCODE_W];

    // Wider opcodes only match the table when their upper bits are zero; anything else is a NOP.
    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign op_in_range = (opcode[OPCODE_W-1:4] == '0);
        end else begin : g_narrow_op
            assign op_in_range = 1'b1;
        end
        if (DATA_W > OPCODE_W) begin : g_operand
            logic unused_operand;
            assign unused_operand = ^insn[DATA_W-OPCODE_W-1:0];
        end
    endgenerate

    assign op = op_in_range ? opcode[3:0] : OP_NOP;

    // Final micro-op step of each instruction in variable-length mode.
    always_comb begin
        fin_step = S2;
        case (op)
            OP_LDA, OP_STA: fin_step = S3;
            OP_ADD, OP_SUB: fin_step = S4;
            default:        fin_step = S2;
        endcase
    end

    always_comb begin
        uop = '0;
        if (step == S0) begin
            uop = C_MI | C_CO;
        end else if (step == S1) begin
            uop = C_RO | C_II | C_CE;
        end else begin
            case (op)
                OP_LDA: begin
                    if (step == S2)      uop = C_MI | C_IO;
                    else if (step == S3) uop = C_RO | C_AI;
                end
                OP_ADD, OP_SUB: begin
                    if (step == S2)      uop = C_MI | C_IO;
                    else if (step == S3) uop = C_RO | C_BI;
                    else if (step == S4) uop = C_EO | C_AI | C_FI | ((op == OP_SUB) ? C_SU : 16'h0000);
                end
                OP_STA: begin
                    if (step == S2)      uop = C_MI | C_IO;
                    else if (step == S3) uop = C_AO | C_RI;
                end
                OP_LDI: if (step == S2) uop = C_IO | C_AI;
                OP_JMP: if (step == S2) uop = C_IO | C_J;
                // Flags only matter here, at step 2 of the conditional jumps.
                OP_JC:  if (step == S2 && cf) uop = C_IO | C_J;
                OP_JZ:  if (step == S2 && zf) uop = C_IO | C_J;
                OP_OUT: if (step == S2) uop = C_AO | C_OI;
                OP_HLT: if (step == S2) uop = C_HLT;
                default: uop = '0;
            endcase
        end
    end

    assign last_raw  = (FIXED_LEN != 0) ? (step == S_LAST) : (step == fin_step);
    assign last      = !rst && !halted && last_raw;
    assign hlt_entry = !halted && (step == S2) && (op == OP_HLT);

    always_comb begin
        ctrl = uop;
        if (rst)         ctrl = '0;
        else if (halted) ctrl = C_HLT;
    end

    // Entering halt holds step at 2 instead of wrapping, so a halted CPU reports where it stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (hlt_entry) begin
                halted <= 1'b1;
            end else if (last || step == S_LAST) begin
                step <= '0;
            end else begin
                step <= step + STEP_W'(1);
            end
        end
    end

endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised microcode sequencer for the 8-bit breadboard-style CPU; it generalises the fixed five-step decoder.
- Drives the full 16-bit control word from the instruction register and the ALU flags.
- Supports variable-length instructions, with early return to fetch after the last useful step.
- Adds conditional jumps on carry and zero, and a latched halt.
- Sits between the instruction register/flag register and every bus-attached datapath unit.

## Interface
Parameters:
- DATA_W, 8, instruction register width; opcode occupies the top OPCODE_W bits.
- OPCODE_W, 4, opcode width; must be ≥4 and ≤DATA_W.
- STEPS, 8, maximum T-states per instruction; must be ≥5.
- STEP_W, 3, step counter width; 2**STEP_W ≥ STEPS.
- FIXED_LEN, 0, 0 = variable length with early return; 1 = every instruction runs all STEPS steps (legacy mode).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- insn  in  DATA_W  instruction register contents.
- cf  in  1  carry flag from the flag register.
- zf  in  1  zero flag from the flag register.
- ctrl  out  16  control word. Bit order, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi.
- step  out  STEP_W  current T-state.
- last  out  1  high when the current step is the final step of the instruction.
- halted  out  1  latched halt state.

## Operation
- opcode = insn[DATA_W-1 -: OPCODE_W], compared against the zero-extended 4-bit codes below. Any code not listed decodes as NOP.
- ctrl is a combinational function of (step, opcode, cf, zf, halted, rst). It must be glitch-free relative to the next rising edge.
- The datapath samples ctrl on that same rising edge.
- Steps 0–1 ignore insn:
  - 0: mi co
  - 1: ro ii ce
- Steps ≥2, per opcode:
  - NOP 0000: step 2 is empty, last.
  - LDA 0001: 2 mi io; 3 ro ai, last.
  - ADD 0010: 2 mi io; 3 ro bi; 4 eo ai fi, last.
  - SUB 0011: as ADD, with su added at step 4.
  - STA 0100: 2 mi io; 3 ao ri, last.
  - LDI 0101: 2 io ai, last.
  - JMP 0110: 2 io j, last.
  - JC 0111: 2 io j if cf=1, otherwise empty; last either way.
  - JZ 1000: as JC, using zf.
  - OUT 1110: 2 ao oi, last.
  - HLT 1111: 2 hlt, last.
- Step counter:
  - If last=1 or step=STEPS-1, step ← 0.
  - Otherwise step ← step+1.
  - With FIXED_LEN=1, last is asserted only at STEPS-1. Steps past an instruction's final micro-op output all-zero ctrl.
- Halt:
  - When step 2 of HLT is reached, halted ← 1 on the next edge.
  - While halted=1: step freezes at its current value, ctrl = hlt only, and last = 0.
  - Only rst clears halted.
- Reset: while rst=1, ctrl is forced to 0 combinationally. The next edge sets step=0 and halted=0. At the first cycle after rst falls, the fetch step (mi co) is presented.

## Timing
- Reset values: step=0, halted=0, last=0, ctrl=0 while rst is asserted.
- Instruction length in cycles:
  - 3: NOP, LDI, JMP, JC, JZ, OUT.
  - 4: LDA, STA.
  - 5: ADD, SUB.
  - With FIXED_LEN=1, every instruction takes STEPS cycles.
- Flags are sampled only during step 2 of JC/JZ. A flag change in any other step has no effect.
- insn must be stable from the edge ending step 1 through the instruction's last step. Changes to insn during steps 0–1 are ignored.
- rst asserted mid-instruction or while halted aborts immediately. There is no partial completion.
- When last=1 and step=STEPS-1 coincide, step wraps once to 0; there is no double advance.
- HLT at step 2 and the entry into halt: hlt is visible one cycle before halted rises. The step counter does not wrap, so step stays 2.

## Test plan
- Reset, then insn=0x1E (LDA 14): ctrl per cycle is 0x4004, 0x1408, 0x4800, 0x1200. step then returns to 0 and last pulses once, at step 3.
- ADD, insn=0x2F: steps 2–4 give 0x4800, 0x1020, 0x0281. SUB, insn=0x3F, gives 0x02C1 at step 4.
- JC, insn=0x73:
  - cf=1: step 2 ctrl=0x0802.
  - cf=0: step 2 ctrl=0x0000.
  - Both are 3 cycles long. Toggling cf during steps 0–1 has no effect.
- HLT, insn=0xF0:
  - Step 2 ctrl=0x8000; halted rises on the next edge.
  - After 10 further cycles, step stays 2 and ctrl stays 0x8000.
  - Asserting rst gives ctrl=0, and after it falls the next cycle shows ctrl=0x4004.
- FIXED_LEN=1, STEPS=6, insn=0x51 (LDI): 6 cycles per instruction; steps 3–5 are 0x0000, and last is high only at step 5.
- Unknown opcode 0x9 behaves as NOP (3 cycles, step 2 ctrl=0). Asserting rst at step 3 of ADD gives step=0 on the next edge.
